tmp101_i2c_reader: RTL and testbench
====================================

Name: tmp101_i2c_reader

Overview:
- Upstream I2C master stage feeding the temperature register and converter.
- On a start request, issues one TMP101 read transaction: START, address byte, slave ACK, one data byte (temperature integer part), master NACK, STOP.
- Returns the received byte with a one-cycle Done pulse.
- Fixed pointer register: reads the power-up default pointer 0x00 (temperature). No pointer write.

Parameters:
- CLOCK_FREQUENCY, 60000000, system clock in Hz.
- I2C_BAUDRATE, 15000, SCL frequency in Hz.
- QUARTER, CLOCK_FREQUENCY/(4*I2C_BAUDRATE), clocks per quarter bit; derived (1000 at defaults).

Ports:
- clock60MHz  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high.
- Start  input  1  level request; sampled only in IDLE. Held high gives back-to-back reads.
- ChipAddress  input  8  {7-bit address, R/W}; latched on accept, transmitted unchanged MSB first.
- Busy  output  1  high from accept until the cycle Done is asserted.
- Done  output  1  one-cycle pulse at end of transaction.
- AckError  output  1  set when the address byte was NACKed; updated with Done.
- ReceivedData  output  8  last good data byte; changes only with Done when AckError=0.
- SCL  output  1  push-pull serial clock; idles high.
- SDA  inout  1  open-drain: drives 0 or Z, never 1. Sampled through a 2-flop synchronizer.

Behaviour:
- Reset values: SCL=1, SDA=Z, Busy=0, Done=0, AckError=0, ReceivedData=0x00, state IDLE, counters 0.
- Reset is honoured mid-transaction: bus released next cycle, no STOP generated.
- Quarter tick: counter 0..QUARTER-1; the tick fires at QUARTER-1. The counter is held at 0 in IDLE.
- Every bit slot is 4 quarters, q0..q3:
  - q0: SCL=0, SDA updated.
  - q1: SCL=0.
  - q2: SCL=1.
  - q3: SCL=1.
  - Read sampling happens at the end of q2.
- States:
  - IDLE: if Start=1, latch ChipAddress, Busy=1, go to START.
  - START: q0/q1 SDA=Z, SCL=1; q2/q3 SDA=0, SCL=1 (falling SDA with SCL high). Then go to ADDR with bit index 7.
  - ADDR: 8 slots, SDA=Z for 1 and 0 for 0, MSB first. Index decrements at end of q3; after index 0, go to ADDR_ACK.
  - ADDR_ACK: SDA=Z. If sampled SDA=0, go to DATA; else set the AckError flag and go to STOP.
  - DATA: SDA=Z, 8 slots; shift in sampled bit MSB first, then go to MNACK.
  - MNACK: SDA=Z (NACK) for one slot, then go to STOP.
  - STOP: q0/q1 SDA=0, SCL 0 then 1; q2/q3 SDA=Z, SCL=1 (rising SDA with SCL high). Then go to FINISH.
  - FINISH: one cycle; Done=1, Busy=0. ReceivedData<=shift register only if no ACK error. AckError output<=flag. Go to IDLE.
- Latency from accept to Done:
  - Good transaction: 20 slots*4*QUARTER + 2 cycles = 80002 at defaults.
  - NACKed address: 11 slots*4*QUARTER + 2 cycles.
- Start ignored while Busy. If Start stays high, the next accept occurs in the IDLE cycle after FINISH.
- ChipAddress changes during a transaction have no effect.
- SCL does not honour clock stretching (TMP101 does not stretch).

Decomposition:
- Shared package: state enum (IDLE, START, ADDR, ADDR_ACK, DATA, MNACK, STOP, FINISH), default CLOCK_FREQUENCY and I2C_BAUDRATE constants.
- One sub-module: i2c_quarter_tick (parameterised divider with enable, outputs tick and 2-bit quarter index).

Test Plan:
Bench uses CLOCK_FREQUENCY=400, I2C_BAUDRATE=10 (QUARTER=10) and a behavioural TMP101 slave, address 0x4B.
- Reset check: Reset held 3 cycles -> SCL=1, SDA=Z, Busy=0, Done=0, ReceivedData=0x00.
- Good read: ChipAddress=0x97, slave returns 0x19, Start pulsed 1 cycle -> SDA bits 1,0,0,1,0,1,1,1; slave ACK; Done pulses once 802 cycles after accept; ReceivedData=0x19, AckError=0.
- Wrong address: ChipAddress=0x91, no slave ACKs -> STOP after the ACK slot; Done 442 cycles after accept; AckError=1; ReceivedData stays 0x19.
- Continuous mode: Start held high, slave returns 0x18 then 0xE7 -> two Done pulses 803 cycles apart; ReceivedData 0x18 then 0xE7.
- Ignored request and address change: Start pulses and ChipAddress=0x91 change mid-transaction -> no extra transaction, address byte remains 0x97.
- Mid-operation reset: Reset asserted during DATA bit 3 -> next cycle SCL=1, SDA=Z, Busy=0, no Done. A following Start gives a clean, correct read.
- Protocol monitor, all tests: SDA never changes while SCL=1 except at START/STOP; SDA is never driven 1.

Source files
------------

// File: rtl/tmp101_i2c_reader_pkg.sv
// Shared constants for the TMP101 temperature reader: default clocking and
// the transaction state encoding.
package tmp101_i2c_reader_pkg;

    localparam int DEFAULT_CLOCK_FREQUENCY = 60_000_000;
    localparam int DEFAULT_I2C_BAUDRATE    = 15_000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_START    = 3'd1;
    localparam state_t ST_ADDR     = 3'd2;
    localparam state_t ST_ADDR_ACK = 3'd3;
    localparam state_t ST_DATA     = 3'd4;
    localparam state_t ST_MNACK    = 3'd5;
    localparam state_t ST_STOP     = 3'd6;
    localparam state_t ST_FINISH   = 3'd7;

endpackage

// File: rtl/tmp101_i2c_reader_quarter_tick.sv
// Quarter-bit divider: tick on the last clock of each QUARTER-long quarter,
// 2-bit quarter index advances on tick; both held at 0 while disabled.
module i2c_quarter_tick #(
    parameter int QUARTER = 1000
) (
    input  logic       clock60MHz,
    input  logic       Reset,
    input  logic       enable,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock60MHz) begin
        if (Reset || !enable) begin
            count   <= '0;
            quarter <= 2'd0;
        end else if (tick) begin
            count   <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/tmp101_i2c_reader.sv
// Single-byte TMP101 temperature read over I2C (START, addr, ACK, data, NACK, STOP).
// Done pulses 20*4*QUARTER+2 cycles after accept (11 slots if NACKed); Start ignored while Busy.
module tmp101_i2c_reader
    import tmp101_i2c_reader_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
    parameter int I2C_BAUDRATE    = DEFAULT_I2C_BAUDRATE
) (
    input  logic       clock60MHz,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] ChipAddress,
    output logic       Busy,
    output logic       Done,
    output logic       AckError,
    output logic [7:0] ReceivedData,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int QUARTER = CLOCK_FREQUENCY / (4 * I2C_BAUDRATE);

    state_t     state;
    logic [7:0] addr_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx;
    logic       ack_bit;
    logic       ack_err;
    logic       run;
    logic       sda_meta;
    logic       sda_sync;
    logic       scl_q;
    logic       sda_low;
    logic       scl_nxt;
    logic       sda_low_nxt;
    logic       tick;
    logic [1:0] quarter;
    logic       in_bus_phase;
    logic       sample;
    logic       slot_end;

    assign in_bus_phase = (state != ST_IDLE) && (state != ST_FINISH);
    assign sample       = tick && (quarter == 2'd2);
    assign slot_end     = tick && (quarter == 2'd3);

    // Divider launches one cycle after accept; that cycle is part of the fixed accept-to-Done frame.
    i2c_quarter_tick #(
        .QUARTER(QUARTER)
    ) u_tick (
        .clock60MHz(clock60MHz),
        .Reset     (Reset),
        .enable    (run && in_bus_phase),
        .tick      (tick),
        .quarter   (quarter)
    );

    always_ff @(posedge clock60MHz) begin
        if (Reset) begin
            state        <= ST_IDLE;
            addr_q       <= 8'h00;
            shift_q      <= 8'h00;
            bit_idx      <= 3'd0;
            ack_bit      <= 1'b1;
            ack_err      <= 1'b0;
            run          <= 1'b0;
            sda_meta     <= 1'b1;
            sda_sync     <= 1'b1;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            AckError     <= 1'b0;
            ReceivedData <= 8'h00;
        end else begin
            sda_meta <= SDA;
            sda_sync <= sda_meta;
            run      <= in_bus_phase;
            Done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        addr_q  <= ChipAddress;
                        ack_err <= 1'b0;
                        Busy    <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (slot_end) begin
                        bit_idx <= 3'd7;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (slot_end) begin
                        if (bit_idx == 3'd0) begin
                            state <= ST_ADDR_ACK;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (sample) begin
                        ack_bit <= sda_sync;
                    end
                    if (slot_end) begin
                        if (!ack_bit) begin
                            bit_idx <= 3'd7;
                            state   <= ST_DATA;
                        end else begin
                            ack_err <= 1'b1;
                            state   <= ST_STOP;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shift_q <= {shift_q[6:0], sda_sync};
                    end
                    if (slot_end) begin
                        if (bit_idx == 3'd0) begin
                            state <= ST_MNACK;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                end
                ST_MNACK: begin
                    if (slot_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (slot_end) begin
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        AckError <= ack_err;
                        if (!ack_err) begin
                            ReceivedData <= shift_q;
                        end
                        state <= ST_FINISH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus levels per state and quarter; registered so SCL and SDA never glitch.
    always_comb begin
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
        case (state)
            ST_START: begin
                sda_low_nxt = quarter[1];
            end
            ST_ADDR: begin
                scl_nxt     = quarter[1];
                sda_low_nxt = ~addr_q[bit_idx];
            end
            ST_ADDR_ACK, ST_DATA, ST_MNACK: begin
                scl_nxt = quarter[1];
            end
            ST_STOP: begin
                scl_nxt     = (quarter != 2'd0);
                sda_low_nxt = ~quarter[1];
            end
            default: begin
                scl_nxt     = 1'b1;
                sda_low_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock60MHz) begin
        if (Reset) begin
            scl_q   <= 1'b1;
            sda_low <= 1'b0;
        end else begin
            scl_q   <= scl_nxt;
            sda_low <= sda_low_nxt;
        end
    end

    assign SCL = scl_q;
    assign SDA = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_tmp101_i2c_reader.sv
// Bench for tmp101_i2c_reader: behavioural TMP101 slave at 0x4B, transaction-level
// output model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_tmp101_i2c_reader;

    localparam int CLK_HZ = 400;
    localparam int BAUD   = 10;
    localparam int Q      = CLK_HZ / (4 * BAUD);
    localparam int L_GOOD = 20 * 4 * Q + 2;
    localparam int L_NACK = 11 * 4 * Q + 2;
    localparam logic [6:0] SLAVE_ADDR = 7'h4B;

    logic       clock60MHz = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] ChipAddress = 8'h00;
    logic       Busy;
    logic       Done;
    logic       AckError;
    logic [7:0] ReceivedData;
    logic       SCL;
    wire        sda;
    logic       sl_low = 1'b0;

    pullup (sda);
    assign sda = sl_low ? 1'b0 : 1'bz;

    always #5 clock60MHz = ~clock60MHz;

    tmp101_i2c_reader #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .I2C_BAUDRATE   (BAUD)
    ) dut (
        .clock60MHz  (clock60MHz),
        .Reset       (Reset),
        .Start       (Start),
        .ChipAddress (ChipAddress),
        .Busy        (Busy),
        .Done        (Done),
        .AckError    (AckError),
        .ReceivedData(ReceivedData),
        .SCL         (SCL),
        .SDA         (sda)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_q[$];
    logic [7:0] slave_q[$];
    logic [7:0] model_q[$];

    always @(posedge clock60MHz) cyc <= cyc + 1;

    // Transaction-level model: accept -> Busy for L-1 cycles -> Done in cycle accept+L.
    bit         m_valid = 0, m_busy = 0, m_done = 0, m_ae = 0, m_active = 0, m_ack = 0;
    logic [7:0] m_rd = 8'h00, m_byte = 8'h00;
    int         m_cnt = 0, m_len = 0;

    always @(negedge clock60MHz) begin
        if (m_valid) begin
            checks++;
            if ({Busy, Done, AckError, ReceivedData} !== {m_busy, m_done, m_ae, m_rd}) begin
                errors++;
                $display("FAIL outputs cycle %0d: busy/done/ackerr/data actual %b %b %b %h required %b %b %b %h",
                         cyc, Busy, Done, AckError, ReceivedData, m_busy, m_done, m_ae, m_rd);
            end
        end
        if (Done === 1'b1) done_q.push_back(cyc);
        if (Reset) begin
            m_valid = 1; m_busy = 0; m_done = 0; m_ae = 0; m_rd = 8'h00;
            m_active = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_active) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_done = 1; m_busy = 0; m_active = 0; m_ae = !m_ack;
                    if (m_ack) m_rd = m_byte;
                end
            end else if (Start) begin
                m_active = 1; m_busy = 1; m_cnt = 1;
                m_ack = (ChipAddress[7:1] == SLAVE_ADDR);
                m_len = m_ack ? L_GOOD : L_NACK;
                if (m_ack) m_byte = (model_q.size() > 0) ? model_q.pop_front() : 8'hFF;
            end
        end
    end

    // Behavioural TMP101 slave, sampling the bus once per system clock.
    bit         p_scl = 1, p_sda = 1;
    int         s_phase = 0, s_bits = 0, starts = 0, stops = 0;
    logic [7:0] s_sh = 8'h00, s_addr = 8'h00, s_byte = 8'hFF;
    logic       s_mack = 1'b0;

    always @(negedge clock60MHz) begin
        bit c_scl, c_sda;
        c_scl = (SCL === 1'b1);
        c_sda = (sda !== 1'b0);
        if (sl_low) begin
            checks++;
            if (sda !== 1'b0) begin
                errors++;
                $display("FAIL sda_pulldown cycle %0d: bus actual %b required 0", cyc, sda);
            end
        end
        if (p_scl && c_scl && p_sda && !c_sda) begin
            starts++; s_phase = 1; s_bits = 0; sl_low = 0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            stops++; s_phase = 0; sl_low = 0;
        end else if (!p_scl && c_scl) begin
            if (s_phase == 1) begin
                s_sh = {s_sh[6:0], c_sda}; s_bits++;
            end else if (s_phase == 4) begin
                s_mack = c_sda;
            end
        end else if (p_scl && !c_scl) begin
            case (s_phase)
                1: if (s_bits == 8) begin
                       s_addr = s_sh;
                       if (s_sh[7:1] == SLAVE_ADDR) begin sl_low = 1; s_phase = 2; end
                       else s_phase = 0;
                   end
                2: begin
                       s_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
                       sl_low = ~s_byte[7]; s_bits = 1; s_phase = 3;
                   end
                3: if (s_bits < 8) begin
                       sl_low = ~s_byte[7 - s_bits]; s_bits++;
                   end else begin
                       sl_low = 0; s_phase = 4;
                   end
                4: s_phase = 0;
                default: s_phase = 0;
            endcase
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock60MHz);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (done_q.size() < target && n < budget) begin
            step(1);
            n++;
        end
        if (done_q.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done pulses actual %0d required %0d", name, done_q.size(), target);
        end
    endtask

    function automatic int done_at(input int idx);
        return (idx < done_q.size()) ? done_q[idx] : -100000;
    endfunction

    task automatic one_read(input logic [7:0] addr, output int a);
        ChipAddress = addr;
        Start = 1'b1;
        a = cyc;
        step(1);
        Start = 1'b0;
    endtask

    int a, nd, st0, sp0;

    initial begin
        repeat (3) @(posedge clock60MHz);
        #1;
        Reset = 1'b0;
        chk("reset_scl", SCL, 1);
        chk("reset_sda", sda, 1);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_data", ReceivedData, 8'h00);
        step(2);

        // Good read of 0x19 from address byte 0x97
        slave_q.push_back(8'h19); model_q.push_back(8'h19);
        nd = done_q.size(); st0 = starts; sp0 = stops;
        one_read(8'h97, a);
        wait_dones(nd + 1, 1000, "good_read");
        step(20);
        chk("good_latency", done_at(nd) - a, 802);
        chk("good_done_count", done_q.size() - nd, 1);
        chk("good_data", ReceivedData, 8'h19);
        chk("good_ackerr", AckError, 0);
        chk("good_addr_byte", s_addr, 8'h97);
        chk("good_master_nack", s_mack, 1);
        chk("good_starts", starts - st0, 1);
        chk("good_stops", stops - sp0, 1);

        // Unanswered address 0x91
        nd = done_q.size(); sp0 = stops;
        one_read(8'h91, a);
        wait_dones(nd + 1, 1000, "nack_read");
        step(5);
        chk("nack_latency", done_at(nd) - a, 442);
        chk("nack_ackerr", AckError, 1);
        chk("nack_data_kept", ReceivedData, 8'h19);
        chk("nack_addr_byte", s_addr, 8'h91);
        chk("nack_stops", stops - sp0, 1);

        // Continuous mode, Start held high
        slave_q.push_back(8'h18); model_q.push_back(8'h18);
        slave_q.push_back(8'hE7); model_q.push_back(8'hE7);
        nd = done_q.size(); st0 = starts;
        ChipAddress = 8'h97;
        Start = 1'b1;
        a = cyc;
        wait_dones(nd + 1, 1000, "cont_first");
        chk("cont_data1", ReceivedData, 8'h18);
        wait_dones(nd + 2, 1000, "cont_second");
        Start = 1'b0;
        step(20);
        chk("cont_latency", done_at(nd) - a, 802);
        chk("cont_gap", done_at(nd + 1) - done_at(nd), 803);
        chk("cont_data2", ReceivedData, 8'hE7);
        chk("cont_ackerr", AckError, 0);
        chk("cont_done_count", done_q.size() - nd, 2);
        chk("cont_starts", starts - st0, 2);

        // Start pulses and address changes while busy
        slave_q.push_back(8'h3C); model_q.push_back(8'h3C);
        nd = done_q.size(); st0 = starts;
        one_read(8'h97, a);
        ChipAddress = 8'h91;
        step(100);
        Start = 1'b1; step(1); Start = 1'b0;
        step(300);
        ChipAddress = 8'h90;
        Start = 1'b1; step(3); Start = 1'b0;
        wait_dones(nd + 1, 1000, "ignore_read");
        step(30);
        chk("ignore_latency", done_at(nd) - a, 802);
        chk("ignore_done_count", done_q.size() - nd, 1);
        chk("ignore_addr_byte", s_addr, 8'h97);
        chk("ignore_data", ReceivedData, 8'h3C);
        chk("ignore_starts", starts - st0, 1);
        chk("ignore_busy", Busy, 0);

        // Reset during DATA bit 3
        slave_q.push_back(8'hFF); model_q.push_back(8'hFF);
        nd = done_q.size(); st0 = starts; sp0 = stops;
        one_read(8'h97, a);
        step(581);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        chk("midreset_scl", SCL, 1);
        chk("midreset_sda", sda, 1);
        chk("midreset_busy", Busy, 0);
        chk("midreset_done", Done, 0);
        step(40);
        chk("midreset_no_done", done_q.size() - nd, 0);
        chk("midreset_starts", starts - st0, 1);
        chk("midreset_no_stop", stops - sp0, 0);

        slave_q.push_back(8'h5A); model_q.push_back(8'h5A);
        nd = done_q.size(); sp0 = stops;
        one_read(8'h97, a);
        wait_dones(nd + 1, 1000, "after_reset_read");
        step(10);
        chk("after_reset_latency", done_at(nd) - a, 802);
        chk("after_reset_data", ReceivedData, 8'h5A);
        chk("after_reset_ackerr", AckError, 0);
        chk("after_reset_addr_byte", s_addr, 8'h97);
        chk("after_reset_stops", stops - sp0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
